// File: rtl/mips.sv
// mips: single-cycle 32-bit MIPS-I integer subset core.
// Holds PC, instruction memory, register file, ALU and data memory; one
// instruction retires per rising clock edge.
// Optional feature macro MIPS_JUMP_LINK_EN: when defined, jal and jr execute;
// when undefined both decode as NOPs.

// Program counter register.
module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  output logic [31:0] OUT
);
  // Load next PC each edge; reset forces fetch from address 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) OUT <= '0;
    else     OUT <= d;
  end
endmodule

// Instruction memory, 256 words, loaded through the write port or back door.
module instr_mem (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [7:0]  addr,
  output logic [31:0] rdata
);
  logic [31:0] InstructionMemory [256];

  // Optional synchronous load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) InstructionMemory[wr_addr] <= wr_data;
  end

  assign rdata = InstructionMemory[addr];
endmodule

// Register file: two combinational reads, one write, $0 hard-wired to zero.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] Registers [32];

  // Architectural registers clear on reset; writes to $0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the register file is architectural state and must reset to zero,
    // whereas IM/DM are plain storage and deliberately carry no reset.
    if (rst) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      Registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : Registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : Registers[ra2];
endmodule

// Data memory, 1024 bytes, big-endian word access on aligned addresses.
module data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] DataMemory [1024];
  logic [9:0] base;

  assign base  = {word_addr, 2'b00};
  assign rdata = {DataMemory[base], DataMemory[base + 10'd1],
                  DataMemory[base + 10'd2], DataMemory[base + 10'd3]};

  // Store word, most significant byte at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      DataMemory[base]         <= wdata[31:24];
      DataMemory[base + 10'd1] <= wdata[23:16];
      DataMemory[base + 10'd2] <= wdata[15:8];
      DataMemory[base + 10'd3] <= wdata[7:0];
    end
  end
endmodule

module mips (
  input logic clk,
  input logic rst
);
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] rd1, rd2, imm_ext, alu_b, alu_result, dm_rdata, wb_data;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_addr;
  logic [15:0] imm;
  logic [25:0] target;

  alu_op_e alu_op;
  logic reg_write, dst_rd, use_imm, zext, mem_write, mem_read;
  logic branch_eq, branch_ne, jump, jump_reg, link;

  pc_reg ProgCounter (.clk(clk), .rst(rst), .d(pc_next), .OUT(pc));

  instr_mem IM (.clk(clk), .wr_en(1'b0), .wr_addr(8'h0), .wr_data(32'h0),
                .addr(pc[9:2]), .rdata(instr));

  reg_file RF (.clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .we(reg_write),
               .wa(wb_addr), .wd(wb_data), .rd1(rd1), .rd2(rd2));

  data_mem DM (.clk(clk), .we(mem_write), .word_addr(alu_result[9:2]),
               .wdata(rd2), .rdata(dm_rdata));

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign target   = instr[25:0];
  assign pc_plus4 = pc + 32'd4;

  // Decode opcode/funct into datapath controls; unlisted encodings stay NOPs.
  always_comb begin
    // NOTE: every control gets a default first so no path infers a latch.
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    dst_rd    = 1'b0;
    use_imm   = 1'b0;
    zext      = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    link      = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_ADD; end
          6'h22: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_SUB; end
          6'h24: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_AND; end
          6'h25: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_OR;  end
          6'h2A: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_SLT; end
          6'h00: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_SLL; end
          6'h02: begin reg_write = 1'b1; dst_rd = 1'b1; alu_op = ALU_SRL; end
`ifdef MIPS_JUMP_LINK_EN
          6'h08: jump_reg = 1'b1;
`endif
          default: ;
        endcase
      end
      6'h08: begin reg_write = 1'b1; use_imm = 1'b1; alu_op = ALU_ADD; end
      6'h0A: begin reg_write = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      6'h0C: begin reg_write = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
      6'h0D: begin reg_write = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR;  end
      6'h0F: begin reg_write = 1'b1; use_imm = 1'b1; alu_op = ALU_LUI; end
      6'h23: begin reg_write = 1'b1; use_imm = 1'b1; mem_read = 1'b1; end
      6'h2B: begin mem_write = 1'b1; use_imm = 1'b1; end
      6'h04: branch_eq = 1'b1;
      6'h05: branch_ne = 1'b1;
      6'h02: jump = 1'b1;
`ifdef MIPS_JUMP_LINK_EN
      6'h03: begin jump = 1'b1; link = 1'b1; reg_write = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign imm_ext = zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = use_imm ? imm_ext : rd2;

  // ALU: 32-bit wrapping arithmetic, signed compare, logical shifts of rt.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = rd1 + alu_b;
      ALU_SUB: alu_result = rd1 - alu_b;
      ALU_AND: alu_result = rd1 & alu_b;
      ALU_OR:  alu_result = rd1 | alu_b;
      ALU_SLT: alu_result = {31'h0, $signed(rd1) < $signed(alu_b)};
      ALU_SLL: alu_result = alu_b << shamt;
      ALU_SRL: alu_result = alu_b >> shamt;
      ALU_LUI: alu_result = {imm, 16'h0};
      default: alu_result = 32'h0;
    endcase
  end

  assign wb_addr = link ? 5'd31 : (dst_rd ? rd : rt);
  assign wb_data = link ? pc_plus4 : (mem_read ? dm_rdata : alu_result);

  // Next-PC select: jr, then j/jal, then taken branch, else sequential.
  always_comb begin
    if (jump_reg)
      pc_next = rd1;
    else if (jump)
      pc_next = {pc_plus4[31:28], target, 2'b00};
    else if ((branch_eq && rd1 == rd2) || (branch_ne && rd1 != rd2))
      pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
    else
      pc_next = pc_plus4;
  end
endmodule

// File: tb/tb_mips.sv
// tb_mips: self-checking bench for the single-cycle mips core.
// Programs are loaded by back-door writes into IM; expected architectural
// state is queued as each program is loaded and compared after it runs.
`timescale 1ns/1ps

module tb_mips;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mips dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  localparam logic [4:0] ZR = 5'd0, T0 = 5'd8, T1 = 5'd9, T2 = 5'd10,
                         T3 = 5'd11, T4 = 5'd12, T5 = 5'd13, RA = 5'd31;

  typedef enum {K_PC, K_REG, K_DMW, K_DMB, K_IMW} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] prog[$];
  vec_t vecs[16];

  function automatic logic [31:0] r_op(logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [4:0] sh,
                                       logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rs,
                                       logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_op(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(kind_e k, int idx);
    case (k)
      K_PC:  return dut.ProgCounter.OUT;
      K_REG: return dut.RF.Registers[idx];
      K_DMW: return {dut.DM.DataMemory[4*idx], dut.DM.DataMemory[4*idx+1],
                     dut.DM.DataMemory[4*idx+2], dut.DM.DataMemory[4*idx+3]};
      K_DMB: return {24'h0, dut.DM.DataMemory[idx]};
      default: return dut.IM.InstructionMemory[idx];
    endcase
  endfunction

  task automatic expect_val(input string name, input kind_e k, input int idx,
                            input logic [31:0] exp);
    sb.push_back('{name, k, idx, exp});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, actual(e.kind, e.idx), e.exp);
    end
  endtask

  // Hold reset, clear IM, load the current program queue.
  task automatic load_and_hold();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) dut.IM.InstructionMemory[i] = 32'h0;
    foreach (prog[i]) dut.IM.InstructionMemory[i] = prog[i];
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_dm(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) dut.DM.DataMemory[i] = v;
  endtask

  initial begin
    vecs[0]  = '{"add",      16'd5,     16'hFFFD, r_op(T0, T1, T2, 5'd0, 6'h20), T2, 32'h00000002};
    vecs[1]  = '{"sub",      16'd5,     16'hFFFD, r_op(T1, T0, T3, 5'd0, 6'h22), T3, 32'hFFFFFFF8};
    vecs[2]  = '{"slt_t",    16'd5,     16'hFFFD, r_op(T1, T0, T4, 5'd0, 6'h2A), T4, 32'h00000001};
    vecs[3]  = '{"slt_f",    16'd5,     16'hFFFD, r_op(T0, T1, T4, 5'd0, 6'h2A), T4, 32'h00000000};
    vecs[4]  = '{"and",      16'h0FF0,  16'h00FF, r_op(T0, T1, T2, 5'd0, 6'h24), T2, 32'h000000F0};
    vecs[5]  = '{"or",       16'h0FF0,  16'h00FF, r_op(T0, T1, T2, 5'd0, 6'h25), T2, 32'h00000FFF};
    vecs[6]  = '{"sll",      16'd0,     16'h0123, r_op(ZR, T1, T2, 5'd4, 6'h00), T2, 32'h00001230};
    vecs[7]  = '{"srl",      16'd0,     16'hFFF0, r_op(ZR, T1, T2, 5'd4, 6'h02), T2, 32'h0FFFFFFF};
    vecs[8]  = '{"andi",     16'd0,     16'hFFFF, i_op(6'h0C, T1, T2, 16'hFF00),  T2, 32'h0000FF00};
    vecs[9]  = '{"ori",      16'd1,     16'd0,    i_op(6'h0D, T0, T2, 16'h8000),  T2, 32'h00008001};
    vecs[10] = '{"slti_t",   16'd0,     16'hFFFD, i_op(6'h0A, T1, T2, 16'hFFFE),  T2, 32'h00000001};
    vecs[11] = '{"slti_f",   16'd5,     16'd0,    i_op(6'h0A, T0, T2, 16'hFFFE),  T2, 32'h00000000};
    vecs[12] = '{"lui",      16'd0,     16'd0,    i_op(6'h0F, ZR, T2, 16'hABCD),  T2, 32'hABCD0000};
    vecs[13] = '{"addi",     16'h7FFF,  16'd0,    i_op(6'h08, T0, T2, 16'hFFFF),  T2, 32'h00007FFE};
    vecs[14] = '{"add_wrap", 16'h8000,  16'd0,    r_op(T0, T0, T2, 5'd0, 6'h20), T2, 32'hFFFF0000};
    vecs[15] = '{"bad_op",   16'd5,     16'd6,    i_op(6'h3F, T0, T2, 16'h1234),  T2, 32'h00000000};

    // Single-instruction vectors: two operand loads, op under test, halt.
    for (int v = 0; v < 16; v++) begin
      prog = '{i_op(6'h08, ZR, T0, vecs[v].a), i_op(6'h08, ZR, T1, vecs[v].b),
               vecs[v].instr, j_op(6'h02, 26'd3)};
      load_and_hold();
      expect_val({vecs[v].name, "_rd"}, K_REG, int'(vecs[v].dst), vecs[v].exp);
      expect_val({vecs[v].name, "_pc"}, K_PC, 0, 32'h0000000C);
      release_rst();
      run(6);
      drain();
    end

    // Arithmetic sequence; PC sampled right after the fifth instruction.
    prog = '{i_op(6'h08, ZR, T0, 16'd5), i_op(6'h08, ZR, T1, 16'hFFFD),
             r_op(T0, T1, T2, 5'd0, 6'h20), r_op(T1, T0, T3, 5'd0, 6'h22),
             r_op(T1, T0, T4, 5'd0, 6'h2A), j_op(6'h02, 26'd5)};
    load_and_hold();
    expect_val("arith_t2", K_REG, int'(T2), 32'h00000002);
    expect_val("arith_t3", K_REG, int'(T3), 32'hFFFFFFF8);
    expect_val("arith_t4", K_REG, int'(T4), 32'h00000001);
    expect_val("arith_pc", K_PC, 0, 32'h00000014);
    release_rst();
    run(5);
    drain();

    // Memory round trip with big-endian byte order and no neighbour spill.
    fill_dm(8'hA5);
    prog = '{i_op(6'h0F, ZR, T0, 16'h1234), i_op(6'h0D, T0, T0, 16'h5678),
             i_op(6'h2B, ZR, T0, 16'd8), i_op(6'h23, ZR, T5, 16'd8),
             j_op(6'h02, 26'd4)};
    load_and_hold();
    expect_val("dm_b8",  K_DMB, 8,  32'h12);
    expect_val("dm_b9",  K_DMB, 9,  32'h34);
    expect_val("dm_b10", K_DMB, 10, 32'h56);
    expect_val("dm_b11", K_DMB, 11, 32'h78);
    expect_val("dm_b7",  K_DMB, 7,  32'hA5);
    expect_val("dm_b12", K_DMB, 12, 32'hA5);
    expect_val("lw_t5",  K_REG, int'(T5), 32'h12345678);
    release_rst();
    run(6);
    drain();

    // Fill array loop: word i = i for i = 0..11, then halt at 0x18.
    fill_dm(8'hA5);
    prog = '{i_op(6'h08, ZR, T0, 16'd0), i_op(6'h08, ZR, T1, 16'd12),
             r_op(ZR, T0, T2, 5'd2, 6'h00), i_op(6'h2B, T2, T0, 16'd0),
             i_op(6'h08, T0, T0, 16'd1), i_op(6'h05, T0, T1, 16'hFFFC),
             j_op(6'h02, 26'd6)};
    load_and_hold();
    for (int w = 0; w < 12; w++) expect_val($sformatf("fill_w%0d", w), K_DMW, w, 32'(w));
    expect_val("fill_w12", K_DMW, 12, 32'hA5A5A5A5);
    expect_val("fill_pc",  K_PC, 0, 32'h00000018);
    release_rst();
    run(70);
    drain();

    // Reset mid-program: asynchronous clear of PC and RF, IM untouched.
    load_and_hold();
    release_rst();
    run(20);
    check("mid_t1_live", actual(K_REG, int'(T1)), 32'd12);
    #2;
    rst = 1'b1;
    #1;
    expect_val("rst_pc", K_PC, 0, 32'h0);
    for (int r = 0; r < 32; r++) expect_val($sformatf("rst_r%0d", r), K_REG, r, 32'h0);
    foreach (prog[i]) expect_val($sformatf("rst_im%0d", i), K_IMW, i, prog[i]);
    drain();
    run(2);
    check("rst_hold_pc", actual(K_PC, 0), 32'h0);
    release_rst();
    run(2);
    check("restart_pc", actual(K_PC, 0), 32'h00000008);
    check("restart_t1", actual(K_REG, int'(T1)), 32'd12);

    // Register zero stays zero through both the array and the read port.
    prog = '{i_op(6'h08, ZR, ZR, 16'd7), r_op(ZR, ZR, T1, 5'd0, 6'h20),
             j_op(6'h02, 26'd2)};
    load_and_hold();
    expect_val("r0_array", K_REG, 0, 32'h0);
    expect_val("r0_read",  K_REG, int'(T1), 32'h0);
    expect_val("r0_pc",    K_PC, 0, 32'h00000008);
    release_rst();
    run(3);
    drain();

    // Undefined opcode and funct: no register change, PC advances by 4.
    prog = '{i_op(6'h08, ZR, T0, 16'h0011), i_op(6'h08, ZR, T1, 16'h0022),
             i_op(6'h3F, T0, T0, 16'hFFFF), r_op(T0, T1, T0, 5'd0, 6'h3F),
             j_op(6'h02, 26'd4)};
    load_and_hold();
    for (int r = 0; r < 32; r++)
      expect_val($sformatf("nop_r%0d", r), K_REG, r,
                 (r == int'(T0)) ? 32'h11 : (r == int'(T1)) ? 32'h22 : 32'h0);
    expect_val("nop_pc", K_PC, 0, 32'h00000010);
    release_rst();
    run(4);
    drain();

    // jal from 0x10 to 0x20, then jr $ra back to the halt at 0x14.
    prog = '{32'h0, 32'h0, 32'h0, 32'h0, j_op(6'h03, 26'd8), j_op(6'h02, 26'd5),
             32'h0, 32'h0, i_op(6'h08, ZR, T0, 16'h0055), r_op(RA, ZR, ZR, 5'd0, 6'h08)};
    load_and_hold();
`ifdef MIPS_JUMP_LINK_EN
    expect_val("jal_ra", K_REG, int'(RA), 32'h00000014);
    expect_val("jal_pc", K_PC, 0, 32'h00000020);
`else
    expect_val("jal_ra", K_REG, int'(RA), 32'h0);
    expect_val("jal_pc", K_PC, 0, 32'h00000014);
`endif
    release_rst();
    run(5);
    drain();
`ifdef MIPS_JUMP_LINK_EN
    expect_val("jr_pc", K_PC, 0, 32'h00000014);
    expect_val("jr_t0", K_REG, int'(T0), 32'h00000055);
`else
    expect_val("nojal_pc", K_PC, 0, 32'h00000014);
    expect_val("nojal_t0", K_REG, int'(T0), 32'h0);
`endif
    run(2);
    drain();

    // jr through a non-$ra register.
    prog = '{i_op(6'h08, ZR, T0, 16'h0040), r_op(T0, ZR, ZR, 5'd0, 6'h08),
             j_op(6'h02, 26'd2)};
    load_and_hold();
`ifdef MIPS_JUMP_LINK_EN
    expect_val("jr_t0_pc", K_PC, 0, 32'h00000040);
`else
    expect_val("jr_t0_pc", K_PC, 0, 32'h00000008);
`endif
    release_rst();
    run(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips.md
# mips

Single-cycle 32-bit MIPS processor core executing an integer subset of MIPS-I, one instruction per clock. It contains its own program counter, instruction memory, register file, ALU and data memory. Benches load programs by back-door writes into instruction memory and inspect architectural state hierarchically.

## Interface
- No parameters; memory sizes are fixed: IM 256 words, DM 1024 bytes.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- Required instance names, for back-door load and inspection:
  - `ProgCounter` register, value in `ProgCounter.OUT` [31:0].
  - `IM.InstructionMemory` [31:0] x256, word-indexed by PC[9:2].
  - `RF.Registers` [31:0] x32.
  - `DM.DataMemory` [7:0] x1024, byte-addressed.

## Operation
- Each cycle: fetch IM[PC[9:2]], decode, read RF, run ALU, optionally access DM, write back, and compute next PC.
- R-type (op 0x00), by funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - sll 0x00, srl 0x02: shift rt by shamt.
  - jr 0x08.
- I-type:
  - addi 0x08, slti 0x0A: sign-extended immediate.
  - andi 0x0C, ori 0x0D: zero-extended immediate.
  - lui 0x0F: {imm,16'h0}.
  - lw 0x23, sw 0x2B.
  - beq 0x04, bne 0x05.
- J-type: j 0x02, jal 0x03.
- Arithmetic is 32-bit two's complement, wraps on overflow, no exceptions.
- Next PC:
  - Default PC+4.
  - Taken branch: PC+4+(signext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jr: rs.
  - jal writes PC+4 to $31.
- Register file:
  - Two combinational read ports, one write port on the rising edge.
  - Register 0 always reads 0; writes to it are discarded.
- Data memory:
  - Effective address = rs + signext(imm), using bits [9:2]; bits [1:0] are ignored.
  - Words are big-endian: byte addr+0 = bits [31:24].
  - Read is combinational; write on the rising edge when sw.
- Any unlisted opcode or funct executes as a NOP: PC+4, no register or memory write.
- A program halts by looping on `j` to itself.
- PC wraps modulo IM size via PC[9:2].

## Timing
- Latency is one cycle per instruction; a result is visible to the next instruction.
- No stalls, hazards or handshakes.
- Reset value: PC = 0 and all 32 registers = 0.
- Reset acts immediately on assertion, including mid-program, and holds while asserted.
- IM and DM are never reset; their contents persist.
- Execution restarts at address 0 on the first rising edge after `rst` deasserts.
- Writeback, DM write and PC update all occur on the same rising edge.

## Configuration
- `MIPS_JUMP_LINK_EN` defined: jal and jr execute as specified.
- Undefined: jal and jr decode as NOPs (PC+4, $31 unchanged); all other instructions are unaffected.

## Test plan
- **Reset:** pulse `rst` during a running program.
  - PC = 0 and all RF = 0 immediately, asynchronously.
  - IM contents are unchanged.
- **Arithmetic:** addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1; sub $t3,$t1,$t0; slt $t4,$t1,$t0.
  - Results: $t2=00000002, $t3=FFFFFFF8, $t4=00000001.
  - PC = 0x14.
- **Memory:** lui $t0,0x1234; ori $t0,$t0,0x5678; sw $t0,8($0); lw $t5,8($0).
  - DM[8..11] = 12,34,56,78.
  - $t5 = 12345678.
- **Fill array:** a loop stores i to word i for i = 0..11 using addi/sll/sw/bne, then j to self.
  - DM words 0..11 read 00000000..0000000B.
  - PC is stuck at the halt address.
- **Register zero:** addi $0,$0,7.
  - $0 still reads 0.
  - An undefined opcode leaves all registers unchanged and advances PC by 4.
- **Jumps:** jal from address 0x10.
  - $ra = 00000014 and PC = target.
  - jr $ra returns to 0x14.
  - With `MIPS_JUMP_LINK_EN` undefined: $ra stays 0 and PC = 0x14.
